// File: rtl/sw_step_pkg.sv
// Shared definitions for the switch/button conditioning stage:
// debounce FSM state encoding and direction polarity constants.
package sw_step_pkg;

    // Debounce channel states: settled low, checking a rise,
    // settled high, checking a fall.
    typedef enum logic [1:0] {
        ST_LO     = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HI     = 2'd2,
        ST_CHK_LO = 2'd3
    } db_state_t;

    // Direction level driven onto the counter's M input.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Debounced level for a given state: high while settled high and
    // while a fall is still being confirmed.
    function automatic logic state_level(input db_state_t st);
        return (st == ST_HI) || (st == ST_CHK_LO);
    endfunction

endpackage

// File: rtl/debounce_core.sv
// One debounce channel: 2-flop synchronizer feeding a 4-state FSM with a
// saturating stability counter. The output only changes after
// DEBOUNCE_CYCLES+1 consecutive agreeing synchronized samples.
module debounce_core
    import sw_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]    sync_reg;
    logic          sync_in;
    db_state_t     state_reg;
    db_state_t     state_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    assign sync_in = sync_reg[1];

    // Two-flop synchronizer bringing the raw asynchronous input into clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], raw};
        end
    end

    // FSM state and stability counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_LO;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: start a check on a change, abort on disagreement,
    // commit once the counter has reached DEBOUNCE_CYCLES.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_LO: begin
                if (sync_in) begin
                    state_next = ST_CHK_HI;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_CHK_HI: begin
                if (!sync_in) begin
                    state_next = ST_LO;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = ST_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!sync_in) begin
                    state_next = ST_CHK_LO;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_CHK_LO: begin
                if (sync_in) begin
                    state_next = ST_HI;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = ST_LO;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_LO;
                cnt_next   = '0;
            end
        endcase
    end

    assign db = state_level(state_reg);

endmodule

// File: rtl/sw_step_conditioner.sv
// Input conditioning for the up/down counter: debounces the direction
// switch (M) and the step button (BTN_DB) and turns each debounced press
// into a single-cycle STEP pulse.
// Optional feature macro: SW_STEP_AUTO_REPEAT_EN adds hold-to-repeat
// pulses (first after REPEAT_DELAY, then every REPEAT_PERIOD cycles).
module sw_step_conditioner
    import sw_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW_MODE,
    input  logic BTN_STEP,
    output logic M,
    output logic BTN_DB,
    output logic STEP
);

    // Parameter sanity checks at elaboration time.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    // Channel 0 is the direction switch, channel 1 the step button.
    logic [1:0] raw_vec;
    logic [1:0] db_vec;
    logic       btn_db;
    logic       btn_db_prev_reg;
    logic       step_reg;
    logic       step_next;
    logic       btn_rise;

    assign raw_vec = {BTN_STEP, SW_MODE};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            debounce_core #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_core (
                .clk  (CLK),
                .rst_n(RST),
                .raw  (raw_vec[gi]),
                .db   (db_vec[gi])
            );
        end
    endgenerate

    assign btn_db   = db_vec[1];
    assign btn_rise = btn_db & ~btn_db_prev_reg;

`ifdef SW_STEP_AUTO_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] DELAY_CNT  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] PERIOD_CNT = HW'(REPEAT_PERIOD);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

    logic [HW-1:0] hold_cnt_reg;
    logic [HW-1:0] hold_cnt_next;
    logic          repeating_reg;
    logic          repeating_next;
    logic          repeat_fire;

    // Hold timer: counts debounced-high cycles; the first target is the
    // initial delay, every later target is the repeat period. Release
    // clears it immediately so a falling edge can never fire.
    always_comb begin
        hold_cnt_next  = hold_cnt_reg;
        repeating_next = repeating_reg;
        repeat_fire    = 1'b0;
        if (!btn_db) begin
            hold_cnt_next  = '0;
            repeating_next = 1'b0;
        end else if (hold_cnt_reg == (repeating_reg ? PERIOD_CNT : DELAY_CNT)) begin
            repeat_fire    = 1'b1;
            hold_cnt_next  = HOLD_ONE;
            repeating_next = 1'b1;
        end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_ONE;
        end
    end

    // Hold timer registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            hold_cnt_reg  <= '0;
            repeating_reg <= 1'b0;
        end else begin
            hold_cnt_reg  <= hold_cnt_next;
            repeating_reg <= repeating_next;
        end
    end

    assign step_next = btn_rise | repeat_fire;
`else
    assign step_next = btn_rise;
`endif

    // Edge detector delay tap and registered STEP pulse.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            btn_db_prev_reg <= 1'b0;
            step_reg        <= 1'b0;
        end else begin
            btn_db_prev_reg <= btn_db;
            step_reg        <= step_next;
        end
    end

    assign M      = db_vec[0] ? DIR_DOWN : DIR_UP;
    assign BTN_DB = btn_db;
    assign STEP   = step_reg;

endmodule

// File: tb/tb_sw_step_conditioner.sv
// Self-checking bench for sw_step_conditioner: directed scenarios plus
// randomized stimulus, compared every cycle against a behavioural model
// (a debounced level flips after DEBOUNCE_CYCLES+1 consecutive disagreeing
// samples seen two cycles late; STEP follows a debounced rise by one cycle;
// optional repeats at fixed offsets from the initial pulse).
module tb_sw_step_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sw  = 1'b0;
    logic btn = 1'b0;
    logic m, btn_db, step;

    sw_step_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .SW_MODE (sw),
        .BTN_STEP(btn),
        .M       (m),
        .BTN_DB  (btn_db),
        .STEP    (step)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Single checking task: counts the comparison, reports a mismatch.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic hist_sw[$];
    logic hist_bt[$];
    logic mdl_m, mdl_db, mdl_db_prev, mdl_step;
    int   run_sw, run_bt;
    int   e_init;
    bit   holding;

    function automatic void deb(input logic s, inout logic out, inout int run);
        if (s != out) begin
            run++;
            if (run == DB + 1) begin
                out = ~out;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endfunction

    task automatic model_reset();
        hist_sw     = '{1'b0, 1'b0};
        hist_bt     = '{1'b0, 1'b0};
        mdl_m       = 1'b0;
        mdl_db      = 1'b0;
        mdl_db_prev = 1'b0;
        mdl_step    = 1'b0;
        run_sw      = 0;
        run_bt      = 0;
        holding     = 0;
        e_init      = 0;
    endtask

    // Advance the model by one rising edge using the inputs present before it.
    task automatic model_edge();
        logic s_sw, s_bt, old_db, rise, fire;
        int t;
        if (!rst) begin
            model_reset();
        end else begin
            s_sw = hist_sw.pop_front();
            s_bt = hist_bt.pop_front();
            hist_sw.push_back(sw);
            hist_bt.push_back(btn);
            old_db = mdl_db;
            fire = 1'b0;
            if (!old_db) begin
                holding = 0;
            end else if (holding) begin
                t = cyc - e_init;
`ifdef SW_STEP_AUTO_REPEAT_EN
                if (t == RD || (t > RD && ((t - RD) % RP) == 0)) fire = 1'b1;
`endif
            end
            rise = old_db && !mdl_db_prev;
            if (rise) begin
                holding = 1;
                e_init  = cyc;
            end
            mdl_step    = rise | fire;
            mdl_db_prev = old_db;
            deb(s_sw, mdl_m, run_sw);
            deb(s_bt, mdl_db, run_bt);
        end
    endtask

    // ---------------- event capture for directed checks ----------------
    int   step_count, first_step_cyc, last_step_cyc, db_rise_cyc, m_rise_cyc;
    logic prev_db_obs, prev_m_obs;

    task automatic clear_events();
        step_count     = 0;
        first_step_cyc = -1;
        last_step_cyc  = -1;
        db_rise_cyc    = -1;
        m_rise_cyc     = -1;
    endtask

    // One clock: update model at the edge, sample DUT 2 time units later.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #2;
        check_val("m", {31'd0, m}, {31'd0, mdl_m});
        check_val("btn_db", {31'd0, btn_db}, {31'd0, mdl_db});
        check_val("step", {31'd0, step}, {31'd0, mdl_step});
        if (step === 1'b1) begin
            step_count++;
            if (first_step_cyc < 0) first_step_cyc = cyc;
            last_step_cyc = cyc;
        end
        if (btn_db === 1'b1 && prev_db_obs !== 1'b1 && db_rise_cyc < 0) db_rise_cyc = cyc;
        if (m === 1'b1 && prev_m_obs !== 1'b1 && m_rise_cyc < 0) m_rise_cyc = cyc;
        prev_db_obs = btn_db;
        prev_m_obs  = m;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int c0, c1;

    initial begin
        model_reset();
        clear_events();
        prev_db_obs = 1'b0;
        prev_m_obs  = 1'b0;

        // Reset state
        rst = 1'b0;
        ticks(3);
        check_val("rst_m", {31'd0, m}, 32'd0);
        check_val("rst_btn_db", {31'd0, btn_db}, 32'd0);
        check_val("rst_step", {31'd0, step}, 32'd0);
        rst = 1'b1;
        ticks(5);
        $display("reset: cycle %0d", cyc);

        // Clean press, then release
        clear_events();
        c0 = cyc;
        btn = 1'b1;
        ticks(20);
        check_val("clean_db_lat", db_rise_cyc - c0, 32'd7);
        check_val("clean_step_lat", first_step_cyc - c0, 32'd8);
        btn = 1'b0;
        ticks(15);
        check_val("clean_step_count", step_count, 32'd1);
        check_val("clean_release_db", {31'd0, btn_db}, 32'd0);
        $display("clean press: steps=%0d cycle %0d", step_count, cyc);

        // Bounce rejection
        clear_events();
        for (int k = 0; k < 4; k++) begin
            btn = ~k[0];
            ticks(2);
        end
        c0 = cyc;
        btn = 1'b1;
        ticks(15);
        check_val("bounce_step_count", step_count, 32'd1);
        check_val("bounce_step_lat", first_step_cyc - c0, 32'd8);
        btn = 1'b0;
        ticks(15);
        $display("bounce: steps=%0d cycle %0d", step_count, cyc);

        // Direction change with a short glitch
        clear_events();
        sw = 1'b1;
        ticks(3);
        sw = 1'b0;
        ticks(3);
        c1 = cyc;
        sw = 1'b1;
        ticks(12);
        check_val("dir_m_lat", m_rise_cyc - c1, 32'd7);
        check_val("dir_m_final", {31'd0, m}, 32'd1);
        $display("direction: m=%0d cycle %0d", m, cyc);

        // Reset during a rising check
        clear_events();
        btn = 1'b1;
        ticks(4);
        rst = 1'b0;
        tick();
        check_val("midrst_m", {31'd0, m}, 32'd0);
        check_val("midrst_btn_db", {31'd0, btn_db}, 32'd0);
        check_val("midrst_step", {31'd0, step}, 32'd0);
        rst = 1'b1;
        clear_events();
        c1 = cyc;
        ticks(12);
        check_val("midrst_db_lat", db_rise_cyc - c1, 32'd7);
        check_val("midrst_step_lat", first_step_cyc - c1, 32'd8);
        sw = 1'b0;
        btn = 1'b0;
        ticks(15);
        $display("reset mid-check: cycle %0d", cyc);

        // Long hold (auto-repeat when enabled)
        clear_events();
        c0 = cyc;
        btn = 1'b1;
        ticks(60);
        btn = 1'b0;
        ticks(20);
`ifdef SW_STEP_AUTO_REPEAT_EN
        check_val("hold_step_count", step_count, 32'd6);
        check_val("hold_last_step", last_step_cyc - c0, 32'd60);
`else
        check_val("hold_step_count", step_count, 32'd1);
        check_val("hold_last_step", last_step_cyc - c0, 32'd8);
`endif
        $display("long hold: steps=%0d cycle %0d", step_count, cyc);

        // Simultaneous switch and button edges
        clear_events();
        c0 = cyc;
        sw = 1'b1;
        btn = 1'b1;
        ticks(12);
        check_val("simul_m_lat", m_rise_cyc - c0, 32'd7);
        check_val("simul_db_lat", db_rise_cyc - c0, 32'd7);
        check_val("simul_step_lat", first_step_cyc - c0, 32'd8);
        sw = 1'b0;
        btn = 1'b0;
        ticks(15);
        $display("simultaneous: cycle %0d", cyc);

        // Randomized segments, occasional reset pulses
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 2) == 0) sw = ~sw;
            if ($urandom_range(0, 1) == 0) btn = ~btn;
            rst = ($urandom_range(0, 40) == 0) ? 1'b0 : 1'b1;
            tick();
            rst = 1'b1;
            ticks($urandom_range(0, 9));
        end
        $display("random: cycle %0d", cyc);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
